// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin sharing of one 4x4 Multiplier between two requesters
// Also holds the shared 4x4 unsigned array Multiplier (a, b -> p).

module Multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] pp [4];
  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = a & {4{b[i]}};
  end
  assign p = {4'b0, pp[0]} + {3'b0, pp[1], 1'b0} + {2'b0, pp[2], 2'b0} + {1'b0, pp[3], 3'b0};
endmodule

module mult_share_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [3:0]       a0,
  input  logic [3:0]       b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [3:0]       a1,
  input  logic [3:0]       b1,
  output logic             gnt1,
  output logic [7:0]       p_out,
  output logic             p_valid,
  output logic             p_id,
  input  logic             p_ready,
  output logic             busy,
  output logic [CNT_W-1:0] ops_cnt
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q;
  logic [3:0]       op_a_q, op_b_q;
  logic             op_id_q, last_id_q, gnt0_q, gnt1_q, p_valid_q, p_id_q;
  logic [7:0]       p_out_q, prod;
  logic [CNT_W-1:0] ops_cnt_q;
  logic             win;
  Multiplier u_mul (.a(op_a_q), .b(op_b_q), .p(prod));
  // a tie goes to whoever was not served last
  assign win = (req0 && req1) ? !last_id_q : req1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_id_q   <= 1'b0;
      last_id_q <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      p_id_q    <= 1'b0;
      ops_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req0 || req1) begin
          op_a_q  <= win ? a1 : a0;
          op_b_q  <= win ? b1 : b0;
          op_id_q <= win;
          gnt0_q  <= !win;
          gnt1_q  <= win;
          state_q <= CALC;
        end
        CALC: begin
          p_out_q   <= prod;
          p_id_q    <= op_id_q;
          p_valid_q <= 1'b1;
          gnt0_q    <= 1'b0;
          gnt1_q    <= 1'b0;
          state_q   <= DONE;
        end
        DONE: if (p_valid_q && p_ready) begin
          p_valid_q <= 1'b0;
          last_id_q <= op_id_q;
          ops_cnt_q <= ops_cnt_q + CNT_W'(1);
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign p_out   = p_out_q;
  assign p_valid = p_valid_q;
  assign p_id    = p_id_q;
  assign busy    = state_q != IDLE;
  assign ops_cnt = ops_cnt_q;
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: transaction-age model compared every cycle, plus directed literal checks
module tb_mult_share_ctrl;
  logic clk = 0, rst_n = 0;
  logic req0 = 0, req1 = 0, p_ready = 0;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic gnt0, gnt1, p_valid, p_id, busy;
  logic [7:0] p_out, ops_cnt;
  int checks = 0, failures = 0;

  mult_share_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .p_out(p_out), .p_valid(p_valid), .p_id(p_id), .p_ready(p_ready),
    .busy(busy), .ops_cnt(ops_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: age 0 = free, 1 = operands held, 2 = result offered
  int         age;
  logic       m_id, m_last;
  logic [3:0] m_a, m_b;
  logic [7:0] m_pout, m_cnt;
  logic       m_pid;
  wire        m_pick = (req0 && req1) ? !m_last : req1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= 0; m_id <= 0; m_last <= 1; m_a <= 0; m_b <= 0;
      m_pout <= 0; m_pid <= 0; m_cnt <= 0;
    end else if (age == 0) begin
      if (req0 || req1) begin
        m_id <= m_pick;
        m_a  <= m_pick ? a1 : a0;
        m_b  <= m_pick ? b1 : b0;
        age  <= 1;
      end
    end else if (age == 1) begin
      m_pout <= 8'(m_a) * 8'(m_b);
      m_pid  <= m_id;
      age    <= 2;
    end else if (p_ready) begin
      m_last <= m_id;
      m_cnt  <= m_cnt + 8'd1;
      age    <= 0;
    end
  end

  logic [8:0] acc_q[$];
  logic       grant_q[$];

  always @(negedge clk) begin
    chk("cycle", {gnt0, gnt1, busy, p_valid, p_id, p_out, ops_cnt},
        {age == 1 && !m_id, age == 1 && m_id, age != 0, age == 2, m_pid, m_pout, m_cnt});
    chk("gnt_excl", gnt0 & gnt1, 0);
    if (rst_n && p_valid && p_ready) acc_q.push_back({p_id, p_out});
    if (gnt0) grant_q.push_back(1'b0);
    if (gnt1) grant_q.push_back(1'b1);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(2);
    rst_n = 1;
    step();
  endtask

  task automatic wait_acc(input int n, input string name);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk); #1;
      got = acc_q.size() >= n;
    end
    chk(name, got, 1);
  endtask

  task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b);
    int na = acc_q.size();
    bit got = 0;
    logic [7:0] prod = 8'(a) * 8'(b);
    if (id) begin req1 = 1; a1 = a; b1 = b; end
    else    begin req0 = 1; a0 = a; b0 = b; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      got = id ? gnt1 : gnt0;
    end
    chk("grant_timeout", got, 1);
    step();
    req0 = 0; req1 = 0;
    wait_acc(na + 1, "accept_timeout");
    if (acc_q.size() > na) chk("result", acc_q[na], {id, prod});
    step();
  endtask

  initial begin
    // tie from reset: both held continuously
    req0 = 1; a0 = 2; b0 = 7; req1 = 1; a1 = 4; b1 = 4; p_ready = 1;
    step(2);
    chk("reset_outs", {gnt0, gnt1, busy, p_valid, p_id, p_out, ops_cnt}, 0);
    rst_n = 1;
    wait_acc(3, "tie_timeout");
    req0 = 0; req1 = 0;
    step(4);
    if (acc_q.size() >= 3) begin
      chk("tie_r0", acc_q[0], {1'b0, 8'd14});
      chk("tie_r1", acc_q[1], {1'b1, 8'd16});
      chk("tie_r2", acc_q[2], {1'b0, 8'd14});
      chk("tie_g", {grant_q[0], grant_q[1], grant_q[2]}, 3'b010);
    end

    // single requests and operand corners
    do_reset();
    chk("reset2_cnt", ops_cnt, 0);
    acc_q.delete(); grant_q.delete();
    do_op(0, 3, 5);
    chk("single_pout", p_out, 15);
    chk("single_pid", p_id, 0);
    chk("single_pvalid", p_valid, 0);
    chk("single_cnt", ops_cnt, 1);
    chk("single_gnts", grant_q.size(), 1);
    do_op(1, 15, 15);
    chk("max_pout", p_out, 8'hE1);
    chk("max_pid", p_id, 1);
    do_op(0, 0, 9);
    chk("zero_pout", p_out, 0);
    chk("cnt3", ops_cnt, 3);

    // backpressure with req0 kept high
    p_ready = 0; req0 = 1; a0 = 6; b0 = 7;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); #1; got = p_valid; end
      chk("bp_valid_timeout", got, 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_hold", {p_out, p_id, p_valid, gnt0, gnt1, ops_cnt}, {8'd42, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3});
    end
    p_ready = 1; req0 = 0;
    step();
    chk("bp_cnt", ops_cnt, 4);
    chk("bp_pvalid", p_valid, 0);
    step(3);
    chk("bp_cnt_stable", ops_cnt, 4);
    chk("bp_idle", busy, 0);

    // reset while result pending
    p_ready = 0; req1 = 1; a1 = 5; b1 = 5;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); #1; got = p_valid; end
      chk("rst_valid_timeout", got, 1);
    end
    step();
    #1 rst_n = 0; req1 = 0;
    #1 chk("async_reset", {gnt0, gnt1, busy, p_valid, p_id, p_out, ops_cnt}, 0);
    step(2);
    acc_q.delete(); grant_q.delete();
    req0 = 1; a0 = 1; b0 = 1; req1 = 1; a1 = 2; b1 = 2; p_ready = 1;
    #1 rst_n = 1;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); #1; got = grant_q.size() > 0; end
      chk("rst_tie_timeout", got, 1);
      if (got) chk("rst_tie_first", grant_q[0], 0);
    end
    req0 = 0; req1 = 0;
    step(5);

    // wrap with random sweep
    do_reset();
    acc_q.delete(); grant_q.delete();
    for (int i = 0; i < 256; i++)
      do_op(1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    chk("wrap_cnt", ops_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
